// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard / forwarding unit: defaults, select
// encoding, tag-entry field layout and width helpers.
package hazard_pkg;

  localparam int ADDR_W_DEF = 5;

  // fwd_sel value meaning "take the operand from the register file"
  localparam int SEL_RF = 0;

  // Tag entry bit layout: {rd, load, wr, valid}
  localparam int TAG_VALID = 0;
  localparam int TAG_WR    = 1;
  localparam int TAG_LOAD  = 2;
  localparam int TAG_RD    = 3;

  function automatic int tagW(input int addrW);
    return addrW + TAG_RD;
  endfunction

  function automatic int selW(input int nfwd);
    return $clog2(nfwd + 1);
  endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// One entry of the instruction tag pipeline: valid/rd/wr/load.
// Only the valid bit is reset; kill turns the incoming entry into a bubble.
module hazard_tag_stage import hazard_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              kill,
  input  logic              inValid,
  input  logic [ADDR_W-1:0] inRd,
  input  logic              inWr,
  input  logic              inLoad,
  output logic              valid,
  output logic [ADDR_W-1:0] rd,
  output logic              wr,
  output logic              load
);

  localparam int TW = tagW(ADDR_W);

  logic [TW-1:0] tagQ;

  // Capture the incoming entry; valid is cleared on reset or kill
  always_ff @(posedge clock) begin
    if (reset) tagQ[TAG_VALID] <= 1'b0;
    else       tagQ[TAG_VALID] <= inValid & ~kill;
    tagQ[TAG_WR]             <= inWr;
    tagQ[TAG_LOAD]           <= inLoad;
    tagQ[TAG_RD +: ADDR_W]   <= inRd;
  end

  assign valid = tagQ[TAG_VALID];
  assign wr    = tagQ[TAG_WR];
  assign load  = tagQ[TAG_LOAD];
  assign rd    = tagQ[TAG_RD +: ADDR_W];

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control for an in-order pipeline:
// load-use and mult/div interlocks, plus per-operand forwarding selects.
module hazard_fwd_unit import hazard_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NPORTS = 2,
  parameter int NFWD   = 2,
  parameter int MD_LAT = 17,
  parameter int SEL_W  = selW(NFWD)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     dec_valid,
  input  logic [NPORTS*ADDR_W-1:0] dec_rs,
  input  logic [ADDR_W-1:0]        dec_rd,
  input  logic                     dec_wr,
  input  logic                     dec_load,
  input  logic                     dec_md,
  input  logic                     flush,
  output logic                     stall,
  output logic [NPORTS*SEL_W-1:0]  fwd_sel,
  output logic                     md_busy
);

  localparam int CNT_W = $clog2(MD_LAT);

  // Entry 0 is X, entries 1..NFWD are the older stages (1 = M, NFWD = W)
  logic [NFWD:0]       stValid;
  logic [NFWD:0]       stWr;
  logic [NFWD:0]       stLoad;
  logic [ADDR_W-1:0]   stRd [0:NFWD];
  logic [NPORTS*ADDR_W-1:0] xRs;

  logic              xHit;
  logic              mdHit;
  logic              luse;
  logic              mdst;
  logic              mdIssue;
  logic [CNT_W-1:0]  mdCnt;
  logic [ADDR_W-1:0] mdRd;
  logic [ADDR_W-1:0] rs;
  logic              unusedLoads;

  for (genvar k = 0; k <= NFWD; k++) begin : gStage
    if (k == 0) begin : gX
      hazard_tag_stage #(.ADDR_W(ADDR_W)) uStage (
        .clock   (clock),
        .reset   (reset),
        .kill    (flush | stall),
        .inValid (dec_valid),
        .inRd    (dec_rd),
        .inWr    (dec_wr),
        .inLoad  (dec_load),
        .valid   (stValid[k]),
        .rd      (stRd[k]),
        .wr      (stWr[k]),
        .load    (stLoad[k])
      );
    end else begin : gOld
      hazard_tag_stage #(.ADDR_W(ADDR_W)) uStage (
        .clock   (clock),
        .reset   (reset),
        .kill    (1'b0),
        .inValid (stValid[k-1]),
        .inRd    (stRd[k-1]),
        .inWr    (stWr[k-1]),
        .inLoad  (1'b0),
        .valid   (stValid[k]),
        .rd      (stRd[k]),
        .wr      (stWr[k]),
        .load    (stLoad[k])
      );
    end
  end

  assign unusedLoads = ^stLoad[NFWD:1];

  // X source registers travel with the X tag; qualified by X valid downstream
  always_ff @(posedge clock) begin
    xRs <= dec_rs;
  end

  // Compare each D source against the X destination and the pending mult/div destination
  always_comb begin
    xHit  = 1'b0;
    mdHit = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      if (dec_rs[p*ADDR_W +: ADDR_W] == stRd[0]) xHit  = 1'b1;
      if (dec_rs[p*ADDR_W +: ADDR_W] == mdRd)    mdHit = 1'b1;
    end
  end

  assign luse = dec_valid & stValid[0] & stLoad[0] & stWr[0] & (stRd[0] != '0) & xHit;
  assign mdst = dec_valid & md_busy &
                (dec_md | ((mdRd != '0) & (mdHit | (dec_wr & (dec_rd == mdRd)))));
  assign stall = (luse | mdst) & ~flush;

  // Youngest matching producer wins: scan oldest to youngest so the last hit sticks
  always_comb begin
    fwd_sel = {NPORTS{SEL_W'(SEL_RF)}};
    rs      = '0;
    for (int p = 0; p < NPORTS; p++) begin
      rs = xRs[p*ADDR_W +: ADDR_W];
      for (int k = NFWD; k >= 1; k--) begin
        if (stValid[0] && (rs != '0) && stValid[k] && stWr[k] && (stRd[k] == rs))
          fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(k);
      end
    end
  end

  assign mdIssue = dec_valid & dec_md & ~stall & ~flush;

  // Mult/div occupancy counter; flush does not cancel an operation in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      mdCnt <= '0;
      mdRd  <= '0;
    end else if (mdIssue) begin
      mdCnt <= CNT_W'(MD_LAT - 1);
      mdRd  <= dec_wr ? dec_rd : '0;
    end else if (mdCnt != '0) begin
      mdCnt <= mdCnt - CNT_W'(1);
    end
  end

  assign md_busy = (mdCnt != '0);

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: table of per-cycle vectors plus
// hand-written mult/div and reset sequences.
module tb_hazard_fwd_unit;

  localparam int AW = 5;
  localparam int NP = 2;
  localparam int NF = 2;
  localparam int ML = 17;
  localparam int SW = 2;
  localparam int NV = 20;

  logic             clock = 1'b0;
  logic             reset;
  logic             dec_valid;
  logic [NP*AW-1:0] dec_rs;
  logic [AW-1:0]    dec_rd;
  logic             dec_wr;
  logic             dec_load;
  logic             dec_md;
  logic             flush;
  logic             stall;
  logic [NP*SW-1:0] fwd_sel;
  logic             md_busy;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic       v;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       md;
    logic       fl;
    logic       eStall;
    logic [3:0] eFwd;
    logic       eBusy;
  } vecT;

  vecT tbl [NV];

  hazard_fwd_unit #(
    .ADDR_W (AW),
    .NPORTS (NP),
    .NFWD   (NF),
    .MD_LAT (ML)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .dec_valid (dec_valid),
    .dec_rs    (dec_rs),
    .dec_rd    (dec_rd),
    .dec_wr    (dec_wr),
    .dec_load  (dec_load),
    .dec_md    (dec_md),
    .flush     (flush),
    .stall     (stall),
    .fwd_sel   (fwd_sel),
    .md_busy   (md_busy)
  );

  always #5 clock = ~clock;

  function automatic vecT mk(input logic v, input int rs0, input int rs1, input int rd,
                             input logic wr, input logic ld, input logic md, input logic fl,
                             input logic eS, input int eF, input logic eB);
    vecT r;
    r.v = v; r.rs0 = 5'(rs0); r.rs1 = 5'(rs1); r.rd = 5'(rd);
    r.wr = wr; r.ld = ld; r.md = md; r.fl = fl;
    r.eStall = eS; r.eFwd = 4'(eF); r.eBusy = eB;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input logic v, input int rs0, input int rs1, input int rd,
                       input logic wr, input logic ld, input logic md, input logic fl);
    dec_valid = v;
    dec_rs    = {5'(rs1), 5'(rs0)};
    dec_rd    = 5'(rd);
    dec_wr    = wr;
    dec_load  = ld;
    dec_md    = md;
    flush     = fl;
  endtask

  initial begin
    int n;
    //                v rs0 rs1 rd wr ld md fl  stall fwd busy
    tbl[0]  = mk(1, 1,  2,  3, 1, 0, 0, 0,  0, 0, 0); // add r3
    tbl[1]  = mk(1, 3,  3,  5, 1, 0, 0, 0,  0, 0, 0); // add r5,r3,r3
    tbl[2]  = mk(1, 3,  0,  6, 1, 0, 0, 0,  0, 5, 0); // X reads r3,r3; r3 in M
    tbl[3]  = mk(0, 0,  0,  0, 0, 0, 0, 0,  0, 2, 0); // X reads r3; r3 in W
    tbl[4]  = mk(1, 1,  0,  4, 1, 1, 0, 0,  0, 0, 0); // lw r4
    tbl[5]  = mk(1, 4,  2,  8, 1, 0, 0, 0,  1, 0, 0); // add r8,r4,r2 -> load-use
    tbl[6]  = mk(1, 4,  2,  8, 1, 0, 0, 0,  0, 0, 0); // held D, X bubble
    tbl[7]  = mk(0, 0,  0,  0, 0, 0, 0, 0,  0, 2, 0); // add in X, lw in W
    tbl[8]  = mk(1, 1,  1,  0, 1, 0, 0, 0,  0, 0, 0); // add r0
    tbl[9]  = mk(1, 1,  1,  0, 1, 0, 0, 0,  0, 0, 0); // add r0
    tbl[10] = mk(1, 0,  0,  9, 1, 0, 0, 0,  0, 0, 0); // add r9,r0,r0
    tbl[11] = mk(1, 0,  0,  0, 1, 1, 0, 0,  0, 0, 0); // lw r0; X reads r0, r0 in M and W
    tbl[12] = mk(1, 0,  0, 10, 1, 0, 0, 0,  0, 0, 0); // reads r0 behind lw r0: no stall
    tbl[13] = mk(1, 1,  1,  2, 1, 0, 0, 0,  0, 0, 0); // add r2
    tbl[14] = mk(1, 3,  3,  2, 1, 0, 0, 0,  0, 0, 0); // add r2
    tbl[15] = mk(1, 2,  1, 11, 1, 0, 0, 0,  0, 0, 0); // add r11,r2,r1
    tbl[16] = mk(0, 0,  0,  0, 0, 0, 0, 0,  0, 1, 0); // r2 in M and W: M wins
    tbl[17] = mk(1, 0,  0, 12, 1, 1, 0, 0,  0, 0, 0); // lw r12
    tbl[18] = mk(1, 12, 0, 13, 1, 0, 0, 1,  0, 0, 0); // load-use + flush
    tbl[19] = mk(0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0); // X is a bubble

    reset = 1'b1;
    apply(1, 3, 3, 3, 1, 1, 1, 0);
    tick();
    tick();
    reset = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_stall", int'(stall), 0);
    chk("reset_fwd", int'(fwd_sel), 0);
    chk("reset_busy", int'(md_busy), 0);

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i].v, int'(tbl[i].rs0), int'(tbl[i].rs1), int'(tbl[i].rd),
            tbl[i].wr, tbl[i].ld, tbl[i].md, tbl[i].fl);
      #1;
      chk($sformatf("row%0d_stall", i), int'(stall), int'(tbl[i].eStall));
      chk($sformatf("row%0d_fwd", i), int'(fwd_sel), int'(tbl[i].eFwd));
      chk($sformatf("row%0d_busy", i), int'(md_busy), int'(tbl[i].eBusy));
      tick();
    end

    // mul r6, then add r7,r6,r1 waits out the whole occupancy
    apply(1, 1, 2, 6, 1, 0, 1, 0);
    #1;
    chk("mul_issue_stall", int'(stall), 0);
    chk("mul_issue_busy", int'(md_busy), 0);
    tick();
    apply(1, 6, 1, 7, 1, 0, 0, 0);
    #1;
    chk("md_busy_start", int'(md_busy), 1);
    n = 0;
    while (stall && n < 40) begin
      n++;
      tick();
      #1;
    end
    chk("md_stall_cycles", n, ML - 1);
    chk("md_busy_release", int'(md_busy), 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("md_add_proceeds", int'(stall), 0);
    chk("md_add_fwd", int'(fwd_sel), 0);
    tick();

    // mul r14, WAW on r14, independent adds, then a second mul cut off by reset
    apply(1, 1, 2, 14, 1, 0, 1, 0);
    #1;
    chk("mul2_issue_stall", int'(stall), 0);
    tick();
    apply(1, 0, 0, 14, 1, 0, 0, 0);
    #1;
    chk("md_waw_stall", int'(stall), 1);
    chk("md_waw_busy", int'(md_busy), 1);
    tick();
    apply(1, 1, 1, 17, 1, 0, 0, 0);
    #1;
    chk("md_indep_stall", int'(stall), 0);
    tick();
    apply(1, 17, 17, 18, 1, 0, 0, 0);
    #1;
    chk("md_indep2_stall", int'(stall), 0);
    tick();
    apply(1, 0, 0, 19, 1, 0, 1, 0);
    #1;
    chk("md_second_issue_stall", int'(stall), 1);
    chk("pre_reset_fwd", int'(fwd_sel), 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("midmd_reset_busy", int'(md_busy), 0);
    chk("midmd_reset_fwd", int'(fwd_sel), 0);
    chk("midmd_reset_stall", int'(stall), 0);
    tick();
    #1;
    chk("post_reset_busy", int'(md_busy), 0);
    chk("post_reset_fwd", int'(fwd_sel), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
